// File: rtl/modrm_encode.sv
// 8086 ModRM encoder: picks the shortest legal mod form for an operand and
// streams the ModRM byte plus 0-2 little-endian displacement bytes into a FIFO.
module modrm_encode #(
  parameter bit FORCE_DISP16 = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        complete,
  input  logic        rm_is_reg,
  input  logic        direct,
  input  logic [2:0]  reg_field,
  input  logic [2:0]  rm_field,
  input  logic [15:0] displacement,
  output logic [1:0]  length,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  input  logic        fifo_full
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MODRM   = 3'd1,
    DISP_LO = 3'd2,
    DISP_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  mod_r, mod_s;
  logic [2:0]  reg_r;
  logic [2:0]  rm_r, rm_s;
  logic [15:0] disp_r;
  logic [1:0]  len_r, len_s;
  logic        wr_s;
  logic [7:0]  byte_s;

  // True when the 16-bit value is the sign extension of its low byte.
  function automatic logic fits_disp8(input logic [15:0] d);
    return (d[15:7] == 9'h000) || (d[15:7] == 9'h1FF);
  endfunction

  // Shortest legal mod form for the operands presented this cycle.
  always_comb begin
    mod_s = 2'b10;
    rm_s  = rm_field;
    len_s = 2'd3;
    if (rm_is_reg) begin
      mod_s = 2'b11;
      len_s = 2'd1;
    end else if (direct) begin
      mod_s = 2'b00;
      rm_s  = 3'b110;
      len_s = 2'd3;
    end else if ((displacement == 16'h0000) && (rm_field != 3'b110)) begin
      // rm=110 with mod 00 means direct addressing, so BP needs a displacement
      mod_s = 2'b00;
      len_s = 2'd1;
    end else if (!FORCE_DISP16 && fits_disp8(displacement)) begin
      mod_s = 2'b01;
      len_s = 2'd2;
    end else begin
      mod_s = 2'b10;
      len_s = 2'd3;
    end
  end

  // State register and operand capture on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      mod_r   <= 2'b00;
      reg_r   <= 3'b000;
      rm_r    <= 3'b000;
      disp_r  <= 16'h0000;
      len_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && start) begin
        mod_r  <= mod_s;
        reg_r  <= reg_field;
        rm_r   <= rm_s;
        disp_r <= displacement;
        len_r  <= len_s;
      end
    end
  end

  // Byte sequencing: a byte is consumed only on an edge with the strobe high.
  always_comb begin
    state_s = state_r;
    wr_s    = 1'b0;
    byte_s  = 8'h00;
    case (state_r)
      IDLE: begin
        if (start) state_s = MODRM;
        else       state_s = IDLE;
      end
      MODRM: begin
        wr_s   = ~fifo_full;
        byte_s = {mod_r, reg_r, rm_r};
        if (wr_s) state_s = (len_r == 2'd1) ? DONE : DISP_LO;
        else      state_s = MODRM;
      end
      DISP_LO: begin
        wr_s   = ~fifo_full;
        byte_s = disp_r[7:0];
        if (wr_s) state_s = (len_r == 2'd3) ? DISP_HI : DONE;
        else      state_s = DISP_LO;
      end
      DISP_HI: begin
        wr_s   = ~fifo_full;
        byte_s = disp_r[15:8];
        if (wr_s) state_s = DONE;
        else      state_s = DISP_HI;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign fifo_wr_en   = wr_s;
  assign fifo_wr_data = byte_s;
  assign busy         = start | (state_r != IDLE);
  assign complete     = (state_r == DONE);
  assign length       = len_r;

endmodule

// File: tb/tb_modrm_encode.sv
// Randomised self-checking bench for modrm_encode; runs a FORCE_DISP16=0 and a
// FORCE_DISP16=1 instance in lockstep against an arithmetic reference model.
module tb_modrm_encode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rm_is_reg = 1'b0;
  logic        direct = 1'b0;
  logic [2:0]  reg_field = 3'd0;
  logic [2:0]  rm_field = 3'd0;
  logic [15:0] displacement = 16'h0000;
  logic        fifo_full = 1'b0;

  logic        busy0, busy1, cmp0, cmp1, wen0, wen1;
  logic [1:0]  len0, len1;
  logic [7:0]  dat0, dat1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modrm_encode #(.FORCE_DISP16(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .complete(cmp0),
    .rm_is_reg(rm_is_reg), .direct(direct), .reg_field(reg_field),
    .rm_field(rm_field), .displacement(displacement), .length(len0),
    .fifo_wr_en(wen0), .fifo_wr_data(dat0), .fifo_full(fifo_full)
  );

  modrm_encode #(.FORCE_DISP16(1'b1)) dut_f16 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .complete(cmp1),
    .rm_is_reg(rm_is_reg), .direct(direct), .reg_field(reg_field),
    .rm_field(rm_field), .displacement(displacement), .length(len1),
    .fifo_wr_en(wen1), .fifo_wr_data(dat1), .fifo_full(fifo_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: byte list of the encoding, from the addressing rules in integer terms.
  task automatic model(input bit rr, input bit dir, input int rg, input int rm,
                       input int d, input bit force16,
                       output int n, output logic [7:0] b [3]);
    int md, r, nd, sd;
    sd = (d >= 32768) ? d - 65536 : d;
    r  = rm;
    if (rr) begin md = 3; nd = 0; end
    else if (dir) begin md = 0; r = 6; nd = 2; end
    else if (d == 0 && rm != 6) begin md = 0; nd = 0; end
    else if (!force16 && sd >= -128 && sd <= 127) begin md = 1; nd = 1; end
    else begin md = 2; nd = 2; end
    n    = 1 + nd;
    b[0] = 8'(md * 64 + rg * 8 + r);
    b[1] = 8'(d % 256);
    b[2] = 8'(d / 256);
  endtask

  task automatic run_enc(input bit rr, input bit dir, input logic [2:0] rg,
                         input logic [2:0] rm, input logic [15:0] d,
                         input int stall_pct, input bit mid_start, input bit stall3);
    int         n [2];
    logic [7:0] e [2][3];
    logic [7:0] ob [2][4];
    int         nb [2];
    bit         done [2], pend [2], stp [2], pw [2];
    logic [7:0] pd [2];
    logic       bsy [2], cmp [2], wen [2];
    logic [1:0] ln [2];
    logic [7:0] dt [2];
    int         stall_left, cyc;
    model(rr, dir, int'(rg), int'(rm), int'(d), 1'b0, n[0], e[0]);
    model(rr, dir, int'(rg), int'(rm), int'(d), 1'b1, n[1], e[1]);
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0; done[k] = 0; pend[k] = 0; stp[k] = 0; pw[k] = 0; pd[k] = 8'h00;
    end
    @(posedge clk); #1;
    rm_is_reg = rr; direct = dir; reg_field = rg; rm_field = rm; displacement = d;
    start = 1'b1; fifo_full = 1'b0;
    @(negedge clk);
    check("busy_on_start0", 32'(busy0), 32'd1);
    check("busy_on_start1", 32'(busy1), 32'd1);
    stall_left = stall3 ? 3 : 0;
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 64) begin
      cyc++;
      @(posedge clk); #1;
      start = mid_start && !done[0] && !done[1] && ($urandom_range(0, 3) == 0);
      // operands change freely after the start edge; they must not be resampled
      rm_is_reg = 1'($urandom); direct = 1'($urandom);
      reg_field = 3'($urandom); rm_field = 3'($urandom); displacement = 16'($urandom);
      if (stall3 && nb[0] == 1 && stall_left > 0) begin
        fifo_full = 1'b1; stall_left--;
      end else if (stall3) fifo_full = 1'b0;
      else fifo_full = ($urandom_range(0, 99) < stall_pct);
      @(negedge clk);
      bsy[0] = busy0; cmp[0] = cmp0; wen[0] = wen0; ln[0] = len0; dt[0] = dat0;
      bsy[1] = busy1; cmp[1] = cmp1; wen[1] = wen1; ln[1] = len1; dt[1] = dat1;
      for (int k = 0; k < 2; k++) begin
        if (pend[k]) begin
          check("busy_drop", 32'(bsy[k]), 32'd0);
          check("idle_wen", 32'(wen[k]), 32'd0);
          check("idle_data", 32'(dt[k]), 32'd0);
          pend[k] = 0;
        end
        if (!done[k]) begin
          check("length", 32'(ln[k]), 32'(n[k]));
          if (stp[k]) check("stall_data", 32'(dt[k]), 32'(pd[k]));
          if (cmp[k]) begin
            check("done_wen", 32'(wen[k]), 32'd0);
            check("done_data", 32'(dt[k]), 32'd0);
            check("cmp_after_wr", 32'(pw[k]), 32'd1);
            check("nbytes", 32'(nb[k]), 32'(n[k]));
            done[k] = 1; pend[k] = 1;
          end else begin
            check("wen_vs_full", 32'(wen[k]), 32'(!fifo_full));
            if (wen[k] && nb[k] < 4) begin
              ob[k][nb[k]] = dt[k]; nb[k]++;
            end
          end
          stp[k] = fifo_full && !cmp[k];
          pd[k]  = dt[k];
          pw[k]  = wen[k];
        end
      end
    end
    if (!(done[0] && done[1])) check("timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; fifo_full = 1'b0;
    @(negedge clk);
    if (pend[0]) check("busy_drop", 32'(busy0), 32'd0);
    if (pend[1]) check("busy_drop", 32'(busy1), 32'd0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < n[k] && i < nb[k]; i++)
        check("byte", 32'(ob[k][i]), 32'(e[k][i]));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'({busy1, busy0}), 32'd0);
    check({tag, "_cmp"},  32'({cmp1, cmp0}), 32'd0);
    check({tag, "_wen"},  32'({wen1, wen0}), 32'd0);
    check({tag, "_data"}, 32'({dat1, dat0}), 32'd0);
    check({tag, "_len"},  32'({len1, len0}), 32'd0);
  endtask

  logic [15:0] rd;
  int          sel;

  initial begin
    @(negedge clk);
    check_reset_state("por");
    @(posedge clk); #1 reset = 1'b0;

    run_enc(1'b1, 1'b0, 3'b010, 3'b001, 16'h0000, 0, 1'b0, 1'b0);
    run_enc(1'b0, 1'b0, 3'b000, 3'b100, 16'h0000, 0, 1'b0, 1'b0);
    run_enc(1'b0, 1'b0, 3'b000, 3'b110, 16'h0000, 0, 1'b0, 1'b0);
    run_enc(1'b0, 1'b0, 3'b001, 3'b000, 16'hFF80, 0, 1'b0, 1'b0);
    run_enc(1'b0, 1'b0, 3'b000, 3'b111, 16'h0100, 0, 1'b0, 1'b0);
    run_enc(1'b0, 1'b1, 3'b111, 3'b011, 16'h1234, 0, 1'b1, 1'b1);

    // Abort mid-encoding: start disp=0x0100 form, reset after the first byte.
    @(posedge clk); #1;
    rm_is_reg = 1'b0; direct = 1'b0; reg_field = 3'b000; rm_field = 3'b111;
    displacement = 16'h0100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("abort_first_wen", 32'(wen0), 32'd1);
    check("abort_first_byte", 32'(dat0), 32'h87);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_state("abort");
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("post_abort");
    run_enc(1'b0, 1'b0, 3'b000, 3'b111, 16'h0100, 0, 1'b0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: rd = 16'h0000;
        1: begin rd = 16'($urandom); rd[15:8] = {8{rd[7]}}; end
        2: begin
          rd = 16'h007F;
          case ($urandom_range(0, 3))
            0: rd = 16'h007F;
            1: rd = 16'h0080;
            2: rd = 16'hFF7F;
            default: rd = 16'hFF80;
          endcase
        end
        default: rd = 16'($urandom);
      endcase
      run_enc(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
              3'($urandom), 3'($urandom), rd, $urandom_range(0, 50), 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
